// File: rtl/spi_flash_reader.sv
// SPI NOR flash read engine: issues a 0x03/0x0B read at a latched address and
// streams DATA_WIDTH-bit words out over valid/ready, stretching SCLK on backpressure.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned ADDR_BYTES   = 3,
  parameter int unsigned DUMMY_CYCLES = 0,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LEN_WIDTH    = 24,
  parameter int unsigned CS_IDLE      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_b_i,
  input  logic                    start_i,
  input  logic [8*ADDR_BYTES-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    spi_cs_b_o,
  output logic                    spi_sclk_o,
  output logic                    spi_mosi_o,
  input  logic                    spi_miso_i
);

  localparam int unsigned ADDR_W  = 8 * ADDR_BYTES;
  localparam int unsigned TX_W    = 8 + ADDR_W;
  localparam int unsigned CNT_MAX = (DUMMY_CYCLES > 32) ? DUMMY_CYCLES : 32;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);
  localparam int unsigned GAP_W   = $clog2(CS_IDLE + 1);
  localparam logic [7:0]  OPCODE  = (DUMMY_CYCLES == 0) ? 8'h03 : 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CS_HOLD, S_GAP
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      bit_q, bit_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [TX_W-2:0]       tx_q, tx_d;
  logic [DATA_WIDTH-2:0] rx_q, rx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic cs_b_q, cs_b_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic busy_q, busy_d, done_q, done_d, valid_q, valid_d, last_q, last_d;

  logic shifting, tick, stall, rise, fall, phase_end, handshake;

  // A word may only start shifting in once the previous one has been taken.
  assign shifting  = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  assign stall     = (state_q == S_DATA) && !sclk_q &&
                     (bit_q == CNT_W'(DATA_WIDTH - 1)) && valid_q && !ready_i;
  assign rise      = (shifting || state_q == S_CS_SETUP) && tick && !sclk_q && !stall;
  assign fall      = shifting && tick && sclk_q;
  assign phase_end = fall && (bit_q == '0);
  assign handshake = valid_q && ready_i;

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_i && len_i != '0) state_d = S_CS_SETUP;
      S_CS_SETUP: if (rise) state_d = S_CMD;
      S_CMD:      if (phase_end) state_d = S_ADDR;
      S_ADDR:     if (phase_end) state_d = (DUMMY_CYCLES != 0) ? S_DUMMY : S_DATA;
      S_DUMMY:    if (phase_end) state_d = S_DATA;
      S_DATA:     if (phase_end && len_q == '0) state_d = S_CS_HOLD;
      S_CS_HOLD:  if (tick) state_d = S_GAP;
      // The last word must drain before a new read can overwrite it.
      S_GAP:      if (gap_q == GAP_W'(CS_IDLE - 1) && (!valid_q || ready_i)) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d   = div_q;   bit_d   = bit_q;   gap_d  = gap_q;  tx_d   = tx_q;
    rx_d    = rx_q;    len_d   = len_q;   dat_d  = dat_q;  cs_b_d = cs_b_q;
    sclk_d  = sclk_q;  mosi_d  = mosi_q;  busy_d = busy_q; done_d = 1'b0;
    valid_d = valid_q; last_d  = last_q;

    if (state_q inside {S_IDLE, S_GAP}) div_d = '0;
    else if (!stall)                    div_d = tick ? '0 : div_q + DIV_W'(1);

    if (handshake) begin
      valid_d = 1'b0;
      done_d  = last_q;
    end

    case (state_q)
      S_IDLE: if (start_i) begin
        if (len_i == '0) begin
          done_d = 1'b1;
        end else begin
          cs_b_d = 1'b0;
          busy_d = 1'b1;
          mosi_d = OPCODE[7];
          tx_d   = {OPCODE[6:0], addr_i};
          bit_d  = CNT_W'(7);
          len_d  = len_i;
          last_d = 1'b0;
        end
      end
      S_CS_HOLD: if (tick) begin
        cs_b_d = 1'b1;
        gap_d  = '0;
      end
      S_GAP: begin
        if (gap_q != GAP_W'(CS_IDLE - 1)) gap_d = gap_q + GAP_W'(1);
        if (state_d == S_IDLE) busy_d = 1'b0;
      end
      default: ;
    endcase

    if (rise) begin
      sclk_d = 1'b1;
      if (state_q == S_DATA) begin
        rx_d = {rx_q[DATA_WIDTH-3:0], spi_miso_i};
        if (bit_q == '0) begin
          dat_d   = {rx_q, spi_miso_i};
          valid_d = 1'b1;
          last_d  = (len_q == LEN_WIDTH'(1));
          len_d   = len_q - LEN_WIDTH'(1);
        end
      end
    end

    // MOSI only moves on the falling edge; the next phase's bit count loads here.
    if (fall) begin
      sclk_d = 1'b0;
      bit_d  = bit_q - CNT_W'(1);
      mosi_d = 1'b0;
      if (state_q inside {S_CMD, S_ADDR}) begin
        mosi_d = tx_q[TX_W-2];
        tx_d   = tx_q << 1;
      end
      if (phase_end) begin
        case (state_q)
          S_CMD: bit_d = CNT_W'(ADDR_W - 1);
          S_ADDR: begin
            mosi_d = 1'b0;
            bit_d  = (DUMMY_CYCLES != 0) ? CNT_W'(DUMMY_CYCLES - 1) : CNT_W'(DATA_WIDTH - 1);
          end
          default: bit_d = CNT_W'(DATA_WIDTH - 1);
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      div_q   <= '0;   bit_q  <= '0;   gap_q  <= '0;   tx_q    <= '0;
      rx_q    <= '0;   len_q  <= '0;   dat_q  <= '0;   cs_b_q  <= 1'b1;
      sclk_q  <= 1'b0; mosi_q <= 1'b0; busy_q <= 1'b0; done_q  <= 1'b0;
      valid_q <= 1'b0; last_q <= 1'b0;
    end else begin
      div_q   <= div_d;   bit_q  <= bit_d;   gap_q  <= gap_d;  tx_q   <= tx_d;
      rx_q    <= rx_d;    len_q  <= len_d;   dat_q  <= dat_d;  cs_b_q <= cs_b_d;
      sclk_q  <= sclk_d;  mosi_q <= mosi_d;  busy_q <= busy_d; done_q <= done_d;
      valid_q <= valid_d; last_q <= last_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign dat_o      = dat_q;
  assign valid_o    = valid_q;
  assign spi_cs_b_o = cs_b_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: three configurations sharing one flash model,
// a vector table of reads plus hand sequences for len=0 and mid-read reset.
module tb_spi_flash_reader;

  typedef struct packed {
    logic [1:0]        inst;
    logic [31:0]       addr;
    logic [23:0]       len;
    logic [7:0]        stall;
    logic              dup;
    logic [7:0]        exp_op;
    logic [31:0]       exp_adr;
    logic [7:0]        exp_rises;
    logic [3:0][31:0]  exp_w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [2:0]  start_r = '0;
  logic [2:0]  ready_r = '0;
  logic [2:0]  miso_r = '0;
  logic [31:0] addr_r [3];
  logic [23:0] len_r [3];
  logic [2:0]  busy_w, done_w, valid_w, cs_w, sclk_w, mosi_w;
  logic [7:0]  dat0, dat2;
  logic [31:0] dat1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_flash_reader u_dut0 (
    .clk_i(clk), .rst_b_i(rst_b), .start_i(start_r[0]), .addr_i(addr_r[0][23:0]),
    .len_i(len_r[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .dat_o(dat0),
    .valid_o(valid_w[0]), .ready_i(ready_r[0]), .spi_cs_b_o(cs_w[0]),
    .spi_sclk_o(sclk_w[0]), .spi_mosi_o(mosi_w[0]), .spi_miso_i(miso_r[0]));

  spi_flash_reader #(.DATA_WIDTH(32)) u_dut1 (
    .clk_i(clk), .rst_b_i(rst_b), .start_i(start_r[1]), .addr_i(addr_r[1][23:0]),
    .len_i(len_r[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .dat_o(dat1),
    .valid_o(valid_w[1]), .ready_i(ready_r[1]), .spi_cs_b_o(cs_w[1]),
    .spi_sclk_o(sclk_w[1]), .spi_mosi_o(mosi_w[1]), .spi_miso_i(miso_r[1]));

  spi_flash_reader #(.DUMMY_CYCLES(8), .ADDR_BYTES(4)) u_dut2 (
    .clk_i(clk), .rst_b_i(rst_b), .start_i(start_r[2]), .addr_i(addr_r[2]),
    .len_i(len_r[2]), .busy_o(busy_w[2]), .done_o(done_w[2]), .dat_o(dat2),
    .valid_o(valid_w[2]), .ready_i(ready_r[2]), .spi_cs_b_o(cs_w[2]),
    .spi_sclk_o(sclk_w[2]), .spi_mosi_o(mosi_w[2]), .spi_miso_i(miso_r[2]));

  function automatic logic [7:0] fmem(input logic [31:0] a);
    case (a)
      32'h100: fmem = 8'hA5;
      32'h101: fmem = 8'h3C;
      32'h102: fmem = 8'h0F;
      32'h103: fmem = 8'hF0;
      default: fmem = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic int ab_of(input int i);
    ab_of = (i == 2) ? 4 : 3;
  endfunction

  function automatic int hdr_of(input int i);
    hdr_of = 8 + 8 * ab_of(i) + ((i == 2) ? 8 : 0);
  endfunction

  function automatic logic [31:0] dat_of(input int i);
    case (i)
      0:       dat_of = {24'h0, dat0};
      1:       dat_of = dat1;
      default: dat_of = {24'h0, dat2};
    endcase
  endfunction

  // Mode-0 flash: captures opcode/address on rising SCLK, shifts data out on falling.
  int          fl_rises [3] = '{0, 0, 0};
  logic [7:0]  fl_op [3];
  logic [31:0] fl_adr [3];
  logic [2:0]  pcs = '1;
  logic [2:0]  psclk = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int k;
      logic [7:0] b;
      if (!cs_w[i] && pcs[i]) begin
        fl_rises[i] = 0;
        fl_op[i]    = '0;
        fl_adr[i]   = '0;
      end
      if (!cs_w[i] && sclk_w[i] && !psclk[i]) begin
        if (fl_rises[i] < 8)                    fl_op[i]  = {fl_op[i][6:0], mosi_w[i]};
        else if (fl_rises[i] < 8 + 8 * ab_of(i)) fl_adr[i] = {fl_adr[i][30:0], mosi_w[i]};
        fl_rises[i] = fl_rises[i] + 1;
      end
      if (!cs_w[i] && !sclk_w[i] && psclk[i] && fl_rises[i] >= hdr_of(i)) begin
        k         = fl_rises[i] - hdr_of(i);
        b         = fmem(fl_adr[i] + 32'(k / 8));
        miso_r[i] = b[3'(7 - k % 8)];
      end
      pcs[i]   = cs_w[i];
      psclk[i] = sclk_w[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] inst, input logic [31:0] addr,
                              input logic [23:0] len, input logic [7:0] stall,
                              input logic dup, input logic [7:0] op,
                              input logic [7:0] rises, input logic [127:0] w);
    vec_t v;
    v.inst = inst; v.addr = addr; v.len = len; v.stall = stall; v.dup = dup;
    v.exp_op = op; v.exp_adr = addr; v.exp_rises = rises; v.exp_w = w;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int i, n, dones, gapc, refall, vcnt, cyc, snap, idle_bad;
    bit seen, pcs_l, finished;
    i = int'(v.inst);
    n = 0; dones = 0; gapc = 0; refall = 0; vcnt = 0; cyc = 0; snap = 0;
    idle_bad = 0; seen = 1'b0; finished = 1'b0;

    @(negedge clk);
    addr_r[i]  = v.addr;
    len_r[i]   = v.len;
    start_r[i] = 1'b1;
    ready_r[i] = (v.stall == 0);
    @(negedge clk);
    start_r[i] = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), 32'(busy_w[i]), 32'd1);
    chk($sformatf("v%0d cs_after_start", idx), 32'(cs_w[i]), 32'd0);
    pcs_l = cs_w[i];

    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (valid_w[i] && !seen) seen = 1'b1;
      ready_r[i] = (v.stall == 0) || (seen && vcnt >= int'(v.stall));
      if (valid_w[i] && ready_r[i]) begin
        if (n < int'(v.len))
          chk($sformatf("v%0d word%0d", idx, n), dat_of(i), v.exp_w[n]);
        else
          chk($sformatf("v%0d extra_word", idx), 32'(n), 32'(v.len));
        n++;
      end
      if (v.stall != 0 && seen && vcnt == 10) snap = fl_rises[i];
      if (v.stall != 0 && seen && vcnt == int'(v.stall) - 1) begin
        chk($sformatf("v%0d stall_sclk", idx), 32'(sclk_w[i]), 32'd0);
        chk($sformatf("v%0d stall_cs", idx), 32'(cs_w[i]), (v.len > 1) ? 32'd0 : 32'd1);
        chk($sformatf("v%0d stall_valid", idx), 32'(valid_w[i]), 32'd1);
        chk($sformatf("v%0d stall_dat", idx), dat_of(i), v.exp_w[0]);
        chk($sformatf("v%0d stall_frozen", idx), 32'(fl_rises[i]), 32'(snap));
      end
      if (seen) vcnt++;
      if (done_w[i]) dones++;
      if (cs_w[i] && busy_w[i]) gapc++;
      if (!cs_w[i] && pcs_l) refall++;
      pcs_l = cs_w[i];
      start_r[i] = v.dup && (cyc == 10);
      if (start_r[i]) begin
        addr_r[i] = 32'h200;
        len_r[i]  = 24'd2;
      end
      if (!busy_w[i]) begin
        finished = 1'b1;
        break;
      end
    end
    start_r[i] = 1'b0;
    chk($sformatf("v%0d finished", idx), 32'(finished), 32'd1);

    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!cs_w[i] || busy_w[i] || valid_w[i]) idle_bad++;
      if (done_w[i]) dones++;
    end
    chk($sformatf("v%0d word_count", idx), 32'(n), 32'(v.len));
    chk($sformatf("v%0d done_pulses", idx), 32'(dones), 32'd1);
    chk($sformatf("v%0d cs_idle_ge4", idx), 32'(gapc >= 4), 32'd1);
    chk($sformatf("v%0d cs_refall", idx), 32'(refall), 32'd0);
    chk($sformatf("v%0d idle_after", idx), 32'(idle_bad), 32'd0);
    chk($sformatf("v%0d opcode", idx), 32'(fl_op[i]), 32'(v.exp_op));
    chk($sformatf("v%0d address", idx), fl_adr[i], v.exp_adr);
    chk($sformatf("v%0d sclk_rises", idx), 32'(fl_rises[i]), 32'(v.exp_rises));
    ready_r[i] = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    int wait_cyc;
    vecs[0] = mk(2'd0, 32'h100, 24'd4, 8'd0,  1'b0, 8'h03, 8'd64,
                 {32'hF0, 32'h0F, 32'h3C, 32'hA5});
    vecs[1] = mk(2'd0, 32'h100, 24'd4, 8'd50, 1'b0, 8'h03, 8'd64,
                 {32'hF0, 32'h0F, 32'h3C, 32'hA5});
    vecs[2] = mk(2'd1, 32'h100, 24'd1, 8'd20, 1'b0, 8'h03, 8'd64,
                 {32'h0, 32'h0, 32'h0, 32'hA53C0FF0});
    vecs[3] = mk(2'd2, 32'h100, 24'd1, 8'd0,  1'b0, 8'h0B, 8'd56,
                 {32'h0, 32'h0, 32'h0, 32'hA5});
    vecs[4] = mk(2'd0, 32'hFE,  24'd3, 8'd0,  1'b1, 8'h03, 8'd56,
                 {32'h0, 32'hA5, 32'hA5, 32'hA4});
    vecs[5] = mk(2'd1, 32'h101, 24'd2, 8'd0,  1'b0, 8'h03, 8'd96,
                 {32'h0, 32'h0, 32'h5F5C5D52, 32'h3C0FF05E});
    for (int i = 0; i < 3; i++) begin
      addr_r[i] = '0;
      len_r[i]  = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst cs_b", 32'(cs_w), 32'h7);
    chk("rst sclk", 32'(sclk_w), 32'h0);
    chk("rst mosi", 32'(mosi_w), 32'h0);
    chk("rst busy", 32'(busy_w), 32'h0);
    chk("rst done", 32'(done_w), 32'h0);
    chk("rst valid", 32'(valid_w), 32'h0);
    chk("rst dat", dat1 | {24'h0, dat0} | {24'h0, dat2}, 32'h0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

    // Zero-length request completes without touching the bus.
    start_r[0] = 1'b1;
    len_r[0]   = 24'd0;
    addr_r[0]  = 32'h100;
    @(negedge clk);
    start_r[0] = 1'b0;
    chk("len0 done", 32'(done_w[0]), 32'd1);
    chk("len0 busy", 32'(busy_w[0]), 32'd0);
    chk("len0 cs", 32'(cs_w[0]), 32'd1);
    @(negedge clk);
    chk("len0 done_one_pulse", 32'(done_w[0]), 32'd0);
    chk("len0 cs_still_high", 32'(cs_w[0]), 32'd1);

    // Reset while the address is being shifted out.
    start_r[0] = 1'b1;
    len_r[0]   = 24'd4;
    ready_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_cyc = 0;
    while (fl_rises[0] < 12 && wait_cyc < 500) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("rst_mid reached_addr", 32'(fl_rises[0] >= 12), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("rst_mid cs_b", 32'(cs_w[0]), 32'd1);
    chk("rst_mid sclk", 32'(sclk_w[0]), 32'd0);
    chk("rst_mid valid", 32'(valid_w[0]), 32'd0);
    chk("rst_mid busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    ready_r[0] = 1'b0;
    repeat (2) @(negedge clk);
    run_vec(6, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
